// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and helpers for the MEM-stage access unit: request sizes,
// controller states, default geometry and the sub-word store merge.
package mem_access_unit_pkg;

    localparam int DEF_MEMORY_WIDTH = 32;
    localparam int DEF_NB_ADDR      = 7;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        LOAD_WAIT = 2'b01,
        RMW_MERGE = 2'b10,
        LOAD_OUT  = 2'b11
    } state_e;

    // Overlay the low bits of new_data onto the selected little-endian lane(s) of old_word.
    function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                                input logic [31:0] new_data,
                                                input logic [1:0]  lane,
                                                input size_e       size);
        logic [31:0] result;
        result = old_word;
        case (size)
            SIZE_BYTE: result[{lane, 3'b000} +: 8]        = new_data[7:0];
            SIZE_HALF: result[{lane[1], 4'b0000} +: 16]   = new_data[15:0];
            default:   result                             = new_data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Combinational load formatter: picks the addressed byte/half lane out of a
// memory word and sign- or zero-extends it to 32 bits.
module mem_access_unit_load_formatter
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  size_e       i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane extraction and extension.
    always_comb begin
        w_byte   = i_word[{i_lane, 3'b000} +: 8];
        w_half   = i_word[{i_lane[1], 4'b0000} +: 16];
        o_result = i_word;
        case (i_size)
            SIZE_BYTE: o_result = i_unsigned ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
            SIZE_HALF: o_result = i_unsigned ? {16'h0000, w_half}   : {{16{w_half[15]}}, w_half};
            SIZE_WORD: o_result = i_word;
            default:   o_result = i_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access controller: turns byte-addressed load/store requests into
// word-addressed data_memory transactions, with RMW for sub-word stores.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int MEMORY_WIDTH = DEF_MEMORY_WIDTH,
    parameter int NB_ADDR      = DEF_NB_ADDR
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic                    i_mem_read,
    input  logic                    i_mem_write,
    input  logic [1:0]              i_size,
    input  logic                    i_unsigned,
    input  logic [31:0]             i_addr,
    input  logic [MEMORY_WIDTH-1:0] i_wdata,
    output logic [MEMORY_WIDTH-1:0] o_rdata,
    output logic                    o_rdata_valid,
    output logic                    o_error,
    output logic                    o_mem_write_data,
    output logic                    o_mem_read_data,
    output logic [NB_ADDR-1:0]      o_write_addr,
    output logic [NB_ADDR-1:0]      o_read_addr,
    output logic [MEMORY_WIDTH-1:0] o_write_data,
    input  logic [MEMORY_WIDTH-1:0] i_mem_data
);

    state_e                  r_state;
    logic [NB_ADDR-1:0]      r_word_addr;
    logic [1:0]              r_lane;
    size_e                   r_size;
    logic                    r_unsigned;
    logic [MEMORY_WIDTH-1:0] r_wdata;
    logic [MEMORY_WIDTH-1:0] r_rdata;
    logic                    r_rdata_valid;
    logic                    r_error;

    logic                    w_accept;
    logic                    w_misaligned;
    logic                    w_out_of_range;
    logic                    w_err;
    logic                    w_load;
    logic                    w_word_store;
    logic                    w_sub_store;
    logic [NB_ADDR-1:0]      w_word_addr;
    logic [MEMORY_WIDTH-1:0] w_fmt;

    assign o_ready        = (r_state == IDLE);
    assign w_accept       = i_valid & o_ready;
    assign w_word_addr    = i_addr[NB_ADDR+1:2];
    assign w_out_of_range = (i_addr[31:NB_ADDR+2] != '0);
    assign w_load         = i_mem_read & ~i_mem_write;
    assign w_word_store   = i_mem_write & ~i_mem_read & (i_size == SIZE_WORD);
    assign w_sub_store    = i_mem_write & ~i_mem_read & (i_size != SIZE_WORD);
    assign o_rdata        = r_rdata;
    assign o_rdata_valid  = r_rdata_valid;
    assign o_error        = r_error;

    // Alignment check per access size; the illegal size counts as misaligned.
    always_comb begin
        case (size_e'(i_size))
            SIZE_BYTE: w_misaligned = 1'b0;
            SIZE_HALF: w_misaligned = i_addr[0];
            SIZE_WORD: w_misaligned = |i_addr[1:0];
            default:   w_misaligned = 1'b1;
        endcase
    end

    // A no-op (neither read nor write) is consumed silently and never flags an error.
    assign w_err = (i_mem_read | i_mem_write) &
                   (w_misaligned | w_out_of_range | (i_mem_read & i_mem_write));

    mem_access_unit_load_formatter u_load_formatter (
        .i_word     (i_mem_data),
        .i_lane     (r_lane),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_result   (w_fmt)
    );

    // Controller FSM with registered request fields and pulse outputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_word_addr   <= '0;
            r_lane        <= 2'b00;
            r_size        <= SIZE_BYTE;
            r_unsigned    <= 1'b0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_rdata_valid <= 1'b0;
            r_error       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_word_addr <= w_word_addr;
                        r_lane      <= i_addr[1:0];
                        r_size      <= size_e'(i_size);
                        r_unsigned  <= i_unsigned;
                        r_wdata     <= i_wdata;
                        if (w_err) begin
                            r_error <= 1'b1;
                        end else if (w_load) begin
                            r_state <= LOAD_WAIT;
                        end else if (w_sub_store) begin
                            r_state <= RMW_MERGE;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                LOAD_WAIT: begin
                    r_rdata       <= w_fmt;
                    r_rdata_valid <= 1'b1;
                    r_state       <= LOAD_OUT;
                end
                RMW_MERGE: r_state <= IDLE;
                LOAD_OUT:  r_state <= IDLE;
                default:   r_state <= IDLE;
            endcase
        end
    end

    // Memory-side strobes: word stores write straight from the inputs, RMW writes the merged word.
    always_comb begin
        o_mem_write_data = 1'b0;
        o_mem_read_data  = 1'b0;
        o_write_addr     = r_word_addr;
        o_read_addr      = w_word_addr;
        o_write_data     = merge_store(i_mem_data, r_wdata, r_lane, r_size);
        case (r_state)
            IDLE: begin
                if (w_accept && !w_err && w_word_store) begin
                    o_mem_write_data = 1'b1;
                    o_write_addr     = w_word_addr;
                    o_write_data     = i_wdata;
                end else if (w_accept && !w_err && (w_load || w_sub_store)) begin
                    o_mem_read_data = 1'b1;
                end else begin
                    o_mem_write_data = 1'b0;
                    o_mem_read_data  = 1'b0;
                end
            end
            RMW_MERGE: o_mem_write_data = 1'b1;
            default: begin
                o_mem_write_data = 1'b0;
                o_mem_read_data  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage access controller that sits directly upstream of data_memory. It converts pipeline load/store requests (byte address, size, signedness) into word-addressed data_memory transactions. Sub-word stores use read-modify-write, and load data is lane-extracted and sign- or zero-extended. Pipeline-side ready/valid handshake; memory-side ports match data_memory in LOW_LATENCY mode (1-cycle read latency).

Parameters:
MEMORY_WIDTH, 32, data word width (fixed at 32 for lane logic)
NB_ADDR, 7, data_memory word-address width (depth 2^NB_ADDR words)

Ports:
i_clock  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_valid  in  1  request present
o_ready  out  1  unit can accept a request this cycle
i_mem_read  in  1  load request
i_mem_write  in  1  store request
i_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
i_unsigned  in  1  zero-extend load (LBU/LHU)
i_addr  in  32  byte address
i_wdata  in  32  store data (sub-word data in low bits)
o_rdata  out  32  formatted load result
o_rdata_valid  out  1  one-cycle pulse, o_rdata valid
o_error  out  1  one-cycle pulse: misaligned / out-of-range / illegal request
o_mem_write_data  out  1  data_memory write enable
o_mem_read_data  out  1  data_memory read enable
o_write_addr  out  NB_ADDR  word write address
o_read_addr  out  NB_ADDR  word read address
o_write_data  out  32  data_memory write data
i_mem_data  in  32  data_memory read data (valid the cycle after read enable)

Behaviour:
- Accept on i_valid & o_ready at a rising edge. o_ready = (state == IDLE). Request fields are registered on acceptance.
- Word address = i_addr[NB_ADDR+1:2]. Byte lane k = addr[1:0] maps to bits [8k+7:8k]; half lane = addr[1]*16. Little-endian.
- Error if any of: i_size==11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:NB_ADDR+2]!=0; i_mem_read & i_mem_write both high. On error: o_error pulses the cycle after acceptance, no memory enable is asserted, no rdata_valid, state stays IDLE.
- i_valid with neither read nor write is a no-op and is consumed.
- Memory-side outputs are combinational from state and registers. Enables are 0 except as listed below.
- FSM states: IDLE, LOAD_WAIT, RMW_MERGE, LOAD_OUT.
  - IDLE + accepted word store: o_mem_write_data=1 in the acceptance cycle (address/data from inputs). Stays IDLE. 1 cycle total.
  - IDLE + accepted sub-word store: o_mem_read_data=1 in the acceptance cycle, then go to RMW_MERGE.
  - RMW_MERGE: merge the selected lane(s) of the registered wdata into i_mem_data, assert o_mem_write_data=1, go to IDLE. o_ready is low for exactly 1 cycle.
  - IDLE + accepted load: o_mem_read_data=1 in the acceptance cycle, then go to LOAD_WAIT.
  - LOAD_WAIT: format i_mem_data into the o_rdata register, go to LOAD_OUT.
  - LOAD_OUT: o_rdata_valid=1, go to IDLE.
- Load latency: o_rdata_valid is high in the second cycle after acceptance. o_rdata holds its value until the next load completes.
- Load formatting: byte/half are sign-extended unless i_unsigned; word is passed through. Formatting lives in the sub-module.
- Store-then-load to the same word on consecutive acceptances returns the new data (the write commits at the edge before the read is sampled).
- Reset (any time, including RMW_MERGE): state → IDLE, a pending RMW write is dropped (memory word unchanged). Reset values: o_rdata=0, o_rdata_valid=0, o_error=0, all enables 0, o_ready=1 after release.

Decomposition:
- Shared header/package: size encodings (SIZE_BYTE/HALF/WORD), FSM state encodings, MEMORY_WIDTH / NB_ADDR defaults, shared with the decode and data_memory instantiation.
- One combinational sub-module, load_formatter: inputs are word, addr[1:0], size, unsigned; output is the 32-bit extended result. It is instantiated once and unit-testable on its own.

Test Plan:
- Word store 0xDEADBEEF @0x04 → write enable 1 cycle, o_write_addr=1, o_write_data=0xDEADBEEF, o_ready stays 1; then word load @0x04 → o_rdata=0xDEADBEEF with valid 2 cycles after acceptance.
- Byte store 0x000000AA @0x06 → read enable at addr 1, next cycle write 0xDEAABEEF, o_ready low exactly 1 cycle.
- Loads on word 0xDEAABEEF: signed byte @0x07 → 0xFFFFFFDE; unsigned byte @0x07 → 0x000000DE; signed half @0x04 → 0xFFFFBEEF; unsigned half @0x06 → 0x0000DEAA.
- Misaligned: word load @0x05, half store @0x03, address 0x200 → o_error pulse each, no enables, o_rdata_valid stays 0, memory unchanged.
- Assert i_reset during RMW_MERGE of byte store 0x55 @0x04 → no write enable, word remains 0xDEAABEEF, all outputs 0, o_ready=1 after release.
- Back-to-back: word store 0x12345678 @0x08 then a load @0x08 in the next cycle → o_rdata=0x12345678.
